// File: rtl/song_sequencer.sv
// Play/pause/skip/auto-advance controller driving song_reader's play, song and reset_player.
// Optional feature macro: SONG_SEQ_LOOP_ALL_EN (auto-advance past the last song loops to song 0).
module song_sequencer #(
  parameter int NUM_SONGS  = 4,
  parameter int GAP_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       play_button,
  input  logic       next_button,
  input  logic       song_done,
  output logic       play,
  output logic       reset_player,
  output logic [1:0] song,
  output logic       gap_active
);

  localparam int CNT_W = $clog2(GAP_CYCLES + 1);
  localparam logic [1:0]       SONG_LAST = 2'(NUM_SONGS - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PAUSED  = 2'd0,
    S_PLAYING = 2'd1,
    S_ADVANCE = 2'd2,
    S_GAP     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             auto_q, auto_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       song_q, song_d;
  logic             play_q, play_d;
  logic             reset_player_q, reset_player_d;
  logic             gap_active_q, gap_active_d;

  function automatic logic [1:0] next_song(input logic [1:0] cur);
    next_song = (cur == SONG_LAST) ? 2'd0 : cur + 2'd1;
  endfunction

  // Next-state, song selection and gap counter logic
  always_comb begin
    state_d = state_q;
    auto_d  = auto_q;
    cnt_d   = cnt_q;
    song_d  = song_q;
    case (state_q)
      S_PAUSED: begin
        if (next_button) begin
          state_d = S_ADVANCE;
          auto_d  = 1'b0;
          song_d  = next_song(song_q);
        end else if (play_button) begin
          state_d = S_PLAYING;
        end else begin
          state_d = S_PAUSED;
        end
      end
      S_PLAYING: begin
        if (next_button) begin
          state_d = S_ADVANCE;
          auto_d  = 1'b0;
          song_d  = next_song(song_q);
        end else if (play_button) begin
          state_d = S_PAUSED;
        end else if (song_done) begin
          state_d = S_ADVANCE;
          auto_d  = 1'b1;
          song_d  = next_song(song_q);
        end else begin
          state_d = S_PLAYING;
        end
      end
      S_ADVANCE: begin
        // song_q already holds the new index here, so 0 means the advance wrapped
        if (!auto_q) begin
          state_d = S_PAUSED;
        end else if (song_q == 2'd0) begin
`ifdef SONG_SEQ_LOOP_ALL_EN
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
`else
          state_d = S_PAUSED;
`endif
        end else begin
          state_d = S_GAP;
          cnt_d   = GAP_LOAD;
        end
      end
      S_GAP: begin
        if (next_button) begin
          state_d = S_ADVANCE;
          auto_d  = 1'b0;
          song_d  = next_song(song_q);
        end else if (play_button) begin
          state_d = S_PAUSED;
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = S_PLAYING;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = S_PAUSED;
      end
    endcase
  end

  // Outputs decoded from the next state so they register on the same edge
  always_comb begin
    play_d         = (state_d == S_PLAYING);
    reset_player_d = (state_d == S_ADVANCE);
    gap_active_d   = (state_d == S_GAP);
  end

  // State, counter and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_PAUSED;
      auto_q         <= 1'b0;
      cnt_q          <= {CNT_W{1'b0}};
      song_q         <= 2'd0;
      play_q         <= 1'b0;
      reset_player_q <= 1'b0;
      gap_active_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      auto_q         <= auto_d;
      cnt_q          <= cnt_d;
      song_q         <= song_d;
      play_q         <= play_d;
      reset_player_q <= reset_player_d;
      gap_active_q   <= gap_active_d;
    end
  end

  assign play         = play_q;
  assign reset_player = reset_player_q;
  assign song         = song_q;
  assign gap_active   = gap_active_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed self-checking bench for song_sequencer at default parameters.
module tb_song_sequencer;

  logic       clk;
  logic       reset;
  logic       play_button;
  logic       next_button;
  logic       song_done;
  logic       play;
  logic       reset_player;
  logic [1:0] song;
  logic       gap_active;

  int checks = 0;
  int errors = 0;

  song_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .play_button  (play_button),
    .next_button  (next_button),
    .song_done    (song_done),
    .play         (play),
    .reset_player (reset_player),
    .song         (song),
    .gap_active   (gap_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ep, input logic erp,
                         input logic [1:0] esong, input logic egap);
    chk({tag, ".play"},         {1'b0, play},         {1'b0, ep});
    chk({tag, ".reset_player"}, {1'b0, reset_player}, {1'b0, erp});
    chk({tag, ".song"},         song,                 esong);
    chk({tag, ".gap_active"},   {1'b0, gap_active},   {1'b0, egap});
  endtask

  task automatic pulse(input int which);
    if (which == 0) play_button = 1'b1;
    else if (which == 1) next_button = 1'b1;
    else song_done = 1'b1;
    tick();
    play_button = 1'b0;
    next_button = 1'b0;
    song_done   = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    play_button = 1'b0;
    next_button = 1'b0;
    song_done   = 1'b0;
    #1;
    chk_all("in_reset", 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_all("idle", 1'b0, 1'b0, 2'd0, 1'b0);
    end

    // 2: play/pause toggle
    pulse(0);
    chk_all("play_on", 1'b1, 1'b0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all("playing", 1'b1, 1'b0, 2'd0, 1'b0);
    end
    pulse(0);
    chk_all("paused", 1'b0, 1'b0, 2'd0, 1'b0);

    // manual skip to song 1 then play
    pulse(1);
    chk_all("skip_adv", 1'b0, 1'b1, 2'd1, 1'b0);
    tick();
    chk_all("skip_paused", 1'b0, 1'b0, 2'd1, 1'b0);
    pulse(0);
    chk_all("play_s1", 1'b1, 1'b0, 2'd1, 1'b0);

    // 3: auto-advance with 8-cycle gap
    pulse(2);
    chk_all("auto_adv", 1'b0, 1'b1, 2'd2, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_all("gap", 1'b0, 1'b0, 2'd2, 1'b1);
    end
    tick();
    chk_all("gap_end", 1'b1, 1'b0, 2'd2, 1'b0);

    // advance to song 3 playing
    pulse(2);
    chk_all("auto_adv3", 1'b0, 1'b1, 2'd3, 1'b0);
    for (int i = 0; i < 9; i++) tick();
    chk_all("play_s3", 1'b1, 1'b0, 2'd3, 1'b0);

    // 4: next and play together, next wins, wraps to 0
    next_button = 1'b1;
    pulse(0);
    chk_all("both_adv", 1'b0, 1'b1, 2'd0, 1'b0);
    tick();
    chk_all("both_paused", 1'b0, 1'b0, 2'd0, 1'b0);
    tick();
    chk_all("both_hold", 1'b0, 1'b0, 2'd0, 1'b0);

    // reach song 3 playing manually
    pulse(1); tick();
    pulse(1); tick();
    pulse(1); tick();
    chk_all("man_s3", 1'b0, 1'b0, 2'd3, 1'b0);
    pulse(0);
    chk_all("play_s3b", 1'b1, 1'b0, 2'd3, 1'b0);

    // 5: auto-advance from last song
    pulse(2);
    chk_all("wrap_adv", 1'b0, 1'b1, 2'd0, 1'b0);
`ifdef SONG_SEQ_LOOP_ALL_EN
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_all("wrap_gap", 1'b0, 1'b0, 2'd0, 1'b1);
    end
    tick();
    chk_all("wrap_play", 1'b1, 1'b0, 2'd0, 1'b0);
    pulse(0);
    chk_all("wrap_pause", 1'b0, 1'b0, 2'd0, 1'b0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();
      chk_all("wrap_stop", 1'b0, 1'b0, 2'd0, 1'b0);
    end
`endif

    // 6: async reset in the middle of a gap
    pulse(0);
    chk_all("play_s0", 1'b1, 1'b0, 2'd0, 1'b0);
    pulse(2);
    chk_all("adv_s1", 1'b0, 1'b1, 2'd1, 1'b0);
    for (int i = 0; i < 4; i++) tick();
    chk_all("gap4", 1'b0, 1'b0, 2'd1, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 1'b0, 2'd0, 1'b0);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all("post_rst", 1'b0, 1'b0, 2'd0, 1'b0);
    end
    pulse(0);
    chk_all("post_rst_play", 1'b1, 1'b0, 2'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
